serial_receiver: RTL and testbench
==================================

Name: serial_receiver

Overview:
- Downstream stage of the binary calculator. Consumes the serial stream produced by the calculator's transceiver output (DataOut / ClkTx / DoutValid) and rebuilds each 32-bit result word.
- Splits the word into its calculator fields and presents it to the next consumer, such as a host interface or scoreboard, through a valid/ready handshake.
- Holds one output word, and flags framing errors and overruns.

Parameters:
- DataSize, 32, serial word width in bits. Field decode is defined for 32 only.
- CntWidth, 6, bit-counter width; must satisfy 2^CntWidth > DataSize.

Ports:
- Clk  input  1  system clock. Single clock domain; ClkTx is derived from Clk.
- Reset  input  1  synchronous, active-high reset.
- ClkTx  input  1  serial bit clock from the calculator; sampled as data in the Clk domain.
- DataIn  input  1  serial data, MSB first.
- DinValid  input  1  frame envelope; high for the duration of one word transfer.
- RxReady  input  1  downstream accepts the word when RxValid & RxReady.
- ClrErr  input  1  clears the sticky FrameErr and Overrun flags.
- RxValid  output  1  holding register contains an unconsumed word.
- RxData  output  32  full word.
- RxOpA  output  8  RxData[31:24], operand A.
- RxOpB  output  8  RxData[23:16], operand B.
- RxResult  output  8  RxData[15:8], ALU result.
- RxSel  output  4  RxData[7:4], ALU selector.
- RxFlags  output  4  RxData[3:0], ALU flags.
- FrameErr  output  1  sticky: frame ended early.
- Overrun  output  1  sticky: completed word dropped.
- Busy  output  1  FSM is not in IDLE.

Behaviour:
- **Interface:** one clock (Clk); reset (Reset) is synchronous, active-high.
- **Reset:** all outputs are 0, the FSM is in IDLE, and the shift register, bit counter and input pipeline registers are 0.
- **Input pipeline:** ClkTx, DataIn and DinValid are each registered once, giving ClkTxQ, DataQ and DinValidQ. ClkTxQ is registered again to give ClkTxQQ.
- **Bit strobe:** BitStb = ClkTxQ & ~ClkTxQQ. On BitStb the shift register does Shift <= {Shift[30:0], DataQ}.
- **FSM states:** IDLE, SHIFT, WAIT_END.
- **IDLE:**
  - DinValidQ=1 → go to SHIFT and set Cnt=0.
  - BitStb is ignored while in IDLE.
- **SHIFT:**
  - On each BitStb, shift and increment Cnt.
  - BitStb with Cnt==DataSize-1 → word complete; go to WAIT_END.
  - DinValidQ=0 before completion → set FrameErr, discard the partial word, go to IDLE.
  - If BitStb and DinValidQ falling arrive in the same cycle, the strobe is processed first. If that strobe completes the word, no error is raised.
- **WAIT_END:**
  - BitStb is ignored.
  - DinValidQ=0 → go to IDLE.
- **Word complete:**
  - The holding register loads {Shift[30:0], DataQ} on the completing edge.
  - RxValid rises in the following cycle.
  - Latency from the ClkTx rising edge carrying bit 0 to RxValid=1 is 3 Clk cycles.
- **Handshake:**
  - RxValid stays high and RxData stays stable until the cycle with RxValid & RxReady. RxValid then falls on the next edge unless a new word loads in that same cycle.
  - RxReady while RxValid=0 has no effect.
- **Overrun:**
  - A word completes while RxValid=1 and it is not accepted in that cycle → set Overrun, drop the new word, keep the old one.
  - A word completes in the same cycle as an accept → load the new word and keep RxValid=1 with no overrun.
- **Error flags:**
  - ClrErr clears FrameErr and Overrun.
  - If ClrErr coincides with a new error event, the new error wins and the flag stays set.
- **Field outputs:** combinational slices of the holding register.
- **Reset mid-frame:** the partial word and the held word are lost. The next frame is received normally only if DinValid rises again; a DinValid that is already high when Reset releases starts a frame, which then likely ends in FrameErr.
- **Busy:** equals (state != IDLE).

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=2'd0, SHIFT=2'd1, WAIT_END=2'd2.
  - Field position constants: OPA_MSB/LSB, OPB_*, RES_*, SEL_*, FLG_*.
  - The DataSize default.
- One sub-module: `rx_edge_detect`, containing the input registers and the BitStb generation.
- FSM, counter, shift register and holding register stay in the top.

Test Plan:
- **Normal word:** send 0xA5_3C_E1_27 MSB first with ClkTx = Clk/4 and DinValid framing → RxValid=1 three cycles after the last ClkTx edge; RxOpA=0xA5, RxOpB=0x3C, RxResult=0xE1, RxSel=0x2, RxFlags=0x7; FrameErr=0.
- **Back-pressure and overrun:** hold RxReady=0 and send 0x11111111 then 0x22222222 → RxData stays 0x11111111 and Overrun=1. Pulse RxReady → RxValid=0. Pulse ClrErr → Overrun=0.
- **Simultaneous accept:** RxReady=1 in the exact cycle the second word completes → RxData=0x22222222, RxValid stays 1, Overrun=0.
- **Short frame:** drop DinValid after 17 bits → FrameErr=1, RxValid remains 0, FSM returns to IDLE. The next full frame of 0x0000FFFF is received correctly.
- **Extra edges:** 34 ClkTx edges inside one DinValid window → exactly one word is captured (the first 32 bits) and no error is raised.
- **Reset mid-frame:** assert Reset for 1 cycle after 10 bits → all outputs are 0. The following frame 0xDEADBEEF decodes correctly.

Source files
------------

// File: rtl/serial_receiver_pkg.sv
// Shared definitions for the serial receiver: FSM state encoding, default word
// width and the bit positions of the calculator fields inside a 32-bit result word.
package serial_receiver_pkg;

  localparam int DATA_SIZE = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    WAIT_END = 2'd2
  } rxState_t;

  // Calculator word layout: {opA, opB, result, sel, flags}
  localparam int OPA_MSB = 31;
  localparam int OPA_LSB = 24;
  localparam int OPB_MSB = 23;
  localparam int OPB_LSB = 16;
  localparam int RES_MSB = 15;
  localparam int RES_LSB = 8;
  localparam int SEL_MSB = 7;
  localparam int SEL_LSB = 4;
  localparam int FLG_MSB = 3;
  localparam int FLG_LSB = 0;

endpackage

// File: rtl/serial_receiver_if.sv
// Word-level output handshake of the serial receiver.
//   RxValid/RxReady : valid/ready pair, transfer on RxValid & RxReady
//   RxData          : full received word
//   RxOpA..RxFlags  : calculator fields sliced from RxData
// master = receiver side, slave = consumer side.
interface serial_receiver_if #(
  parameter int DataSize = 32
);
  logic                RxValid;
  logic                RxReady;
  logic [DataSize-1:0] RxData;
  logic [7:0]          RxOpA;
  logic [7:0]          RxOpB;
  logic [7:0]          RxResult;
  logic [3:0]          RxSel;
  logic [3:0]          RxFlags;

  modport master (
    output RxValid, RxData, RxOpA, RxOpB, RxResult, RxSel, RxFlags,
    input  RxReady
  );

  modport slave (
    input  RxValid, RxData, RxOpA, RxOpB, RxResult, RxSel, RxFlags,
    output RxReady
  );
endinterface

// File: rtl/serial_receiver_rx_edge_detect.sv
// Input stage of the serial receiver: registers the serial inputs once and
// produces a one-cycle strobe on each rising edge of the registered bit clock.
//   Clk, Reset          : system clock, synchronous active-high reset
//   ClkTx/DataIn/DinValid : raw serial inputs (Clk domain)
//   DataQ, DinValidQ    : registered data and frame envelope
//   BitStb              : ClkTxQ & ~ClkTxQQ, aligned with the matching DataQ
module rx_edge_detect (
  input  logic Clk,
  input  logic Reset,
  input  logic ClkTx,
  input  logic DataIn,
  input  logic DinValid,
  output logic DataQ,
  output logic DinValidQ,
  output logic BitStb
);
  logic clkTxQ;
  logic clkTxQQ;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      clkTxQ    <= 1'b0;
      clkTxQQ   <= 1'b0;
      DataQ     <= 1'b0;
      DinValidQ <= 1'b0;
    end else begin
      clkTxQ    <= ClkTx;
      clkTxQQ   <= clkTxQ;
      DataQ     <= DataIn;
      DinValidQ <= DinValid;
    end
  end

  assign BitStb = clkTxQ & ~clkTxQQ;
endmodule

// File: rtl/serial_receiver.sv
// Serial receiver: rebuilds 32-bit calculator result words from the
// DataOut/ClkTx/DoutValid stream, holds one word for a valid/ready consumer,
// and flags framing errors and overruns.
//   Clk, Reset            : system clock, synchronous active-high reset
//   ClkTx, DataIn, DinValid : serial bit clock, MSB-first data, frame envelope
//   ClrErr                : clears sticky FrameErr / Overrun
//   rx                    : word handshake + field slices (master side)
//   FrameErr, Overrun     : sticky error flags
//   Busy                  : FSM not in IDLE
module serial_receiver
  import serial_receiver_pkg::*;
#(
  parameter int DataSize = DATA_SIZE,
  parameter int CntWidth = 6
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              ClkTx,
  input  logic              DataIn,
  input  logic              DinValid,
  input  logic              ClrErr,
  serial_receiver_if.master rx,
  output logic              FrameErr,
  output logic              Overrun,
  output logic              Busy
);
  logic                dataQ;
  logic                dinValidQ;
  logic                bitStb;

  rxState_t            state;
  rxState_t            stateNext;
  logic [CntWidth-1:0] cnt;
  logic [DataSize-1:0] shiftReg;
  logic [DataSize-1:0] holdReg;
  logic [DataSize-1:0] wordIn;
  logic                rxValidR;
  logic                wordDone;
  logic                frameAbort;
  logic                accept;
  logic                loadWord;

  rx_edge_detect uEdge (
    .Clk      (Clk),
    .Reset    (Reset),
    .ClkTx    (ClkTx),
    .DataIn   (DataIn),
    .DinValid (DinValid),
    .DataQ    (dataQ),
    .DinValidQ(dinValidQ),
    .BitStb   (bitStb)
  );

  // Word as it stands after the current strobe's shift.
  assign wordIn = {shiftReg[DataSize-2:0], dataQ};

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= stateNext;
  end

  // A strobe that finishes the word wins over a coincident envelope drop.
  always_comb begin
    stateNext  = state;
    wordDone   = 1'b0;
    frameAbort = 1'b0;
    unique case (state)
      IDLE:     if (dinValidQ) stateNext = SHIFT;
      SHIFT: begin
        if (bitStb && cnt == CntWidth'(DataSize - 1)) begin
          wordDone  = 1'b1;
          stateNext = WAIT_END;
        end else if (!dinValidQ) begin
          frameAbort = 1'b1;
          stateNext  = IDLE;
        end
      end
      WAIT_END: if (!dinValidQ) stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  assign accept   = rxValidR & rx.RxReady;
  // Load only into a free slot or one being emptied this cycle.
  assign loadWord = wordDone & (~rxValidR | accept);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt      <= '0;
      shiftReg <= '0;
      holdReg  <= '0;
      rxValidR <= 1'b0;
      FrameErr <= 1'b0;
      Overrun  <= 1'b0;
    end else begin
      if (state == IDLE && dinValidQ)   cnt <= '0;
      else if (state == SHIFT && bitStb) cnt <= cnt + CntWidth'(1);

      if (state == SHIFT && bitStb) shiftReg <= wordIn;

      if (loadWord) holdReg <= wordIn;

      if (loadWord)    rxValidR <= 1'b1;
      else if (accept) rxValidR <= 1'b0;

      // New error events take priority over ClrErr.
      if (frameAbort)  FrameErr <= 1'b1;
      else if (ClrErr) FrameErr <= 1'b0;

      if (wordDone && !loadWord) Overrun <= 1'b1;
      else if (ClrErr)           Overrun <= 1'b0;
    end
  end

  assign rx.RxValid  = rxValidR;
  assign rx.RxData   = holdReg;
  assign rx.RxOpA    = holdReg[OPA_MSB:OPA_LSB];
  assign rx.RxOpB    = holdReg[OPB_MSB:OPB_LSB];
  assign rx.RxResult = holdReg[RES_MSB:RES_LSB];
  assign rx.RxSel    = holdReg[SEL_MSB:SEL_LSB];
  assign rx.RxFlags  = holdReg[FLG_MSB:FLG_LSB];
  assign Busy        = (state != IDLE);
endmodule

// File: tb/tb_serial_receiver.sv
module tb_serial_receiver;
  logic Clk = 1'b0;
  logic Reset;
  logic ClkTx, DataIn, DinValid, ClrErr;
  logic FrameErr, Overrun, Busy;

  serial_receiver_if bus ();

  serial_receiver dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .ClkTx   (ClkTx),
    .DataIn  (DataIn),
    .DinValid(DinValid),
    .ClrErr  (ClrErr),
    .rx      (bus),
    .FrameErr(FrameErr),
    .Overrun (Overrun),
    .Busy    (Busy)
  );

  always #5 Clk = ~Clk;

  int nChecks = 0;
  int nFail   = 0;

  typedef struct {
    logic [31:0] word;
    int          nBits;
    bit          preAcc;
    bit          preClr;
    int          mode;      // 0 plain, 1 latency checks, 2 accept on completion cycle
    bit          expValid;
    logic [31:0] expData;
    bit          expFe;
    bit          expOv;
  } vec_t;

  vec_t vecs[7];

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ClkTx = Clk/4: low two cycles (data changes), high two cycles.
  task automatic sendBits(input logic [31:0] w, input int n, input int mode);
    logic [33:0] ext;
    ext = {w, 2'b11};
    for (int i = 0; i < n; i++) begin
      tick; ClkTx = 1'b0; DataIn = ext[33-i];
      tick;
      tick; ClkTx = 1'b1;
      if (i == n - 1 && mode == 1) begin
        @(negedge Clk); chk("lat_cycle1", bus.RxValid, 0);
      end
      tick;
      if (i == n - 1 && mode == 2) bus.RxReady = 1'b1;
      if (i == n - 1 && mode == 1) begin
        @(negedge Clk); chk("lat_cycle2", bus.RxValid, 0);
      end
    end
  endtask

  task automatic frame(input logic [31:0] w, input int n, input int mode);
    tick; DinValid = 1'b1;
    sendBits(w, n, mode);
    tick; ClkTx = 1'b0; bus.RxReady = 1'b0;
    if (mode == 1) begin
      @(negedge Clk); chk("lat_cycle3", bus.RxValid, 1);
    end
    tick;
    tick; DinValid = 1'b0;
    repeat (4) tick;
  endtask

  task automatic checkOut(input string tag, input bit v, input logic [31:0] d,
                          input bit fe, input bit ov);
    @(negedge Clk);
    chk({tag, "_valid"}, bus.RxValid, v);
    if (v) begin
      chk({tag, "_data"},   bus.RxData,   d);
      chk({tag, "_opa"},    bus.RxOpA,    d[31:24]);
      chk({tag, "_opb"},    bus.RxOpB,    d[23:16]);
      chk({tag, "_res"},    bus.RxResult, d[15:8]);
      chk({tag, "_sel"},    bus.RxSel,    d[7:4]);
      chk({tag, "_flags"},  bus.RxFlags,  d[3:0]);
    end
    chk({tag, "_frameErr"}, FrameErr, fe);
    chk({tag, "_overrun"},  Overrun,  ov);
    chk({tag, "_busy"},     Busy,     0);
  endtask

  task automatic runVec(input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    if (vecs[idx].preAcc) begin tick; bus.RxReady = 1'b1; tick; bus.RxReady = 1'b0; end
    if (vecs[idx].preClr) begin tick; ClrErr = 1'b1; tick; ClrErr = 1'b0; end
    frame(vecs[idx].word, vecs[idx].nBits, vecs[idx].mode);
    checkOut(tag, vecs[idx].expValid, vecs[idx].expData, vecs[idx].expFe, vecs[idx].expOv);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //        word          n  acc clr mode  V  data          FE OV
    vecs[0] = '{32'h11111111, 32, 1, 0, 0, 1, 32'h11111111, 0, 0};  // consume previous, hold new
    vecs[1] = '{32'h22222222, 32, 0, 0, 0, 1, 32'h11111111, 0, 1};  // overrun keeps old word
    vecs[2] = '{32'h11111111, 32, 0, 0, 0, 1, 32'h11111111, 0, 0};
    vecs[3] = '{32'h22222222, 32, 0, 0, 2, 1, 32'h22222222, 0, 0};  // accept on completion cycle
    vecs[4] = '{32'h12345678, 17, 1, 0, 0, 0, 32'h0,        1, 0};  // short frame
    vecs[5] = '{32'h0000FFFF, 32, 0, 0, 0, 1, 32'h0000FFFF, 1, 0};  // error stays sticky
    vecs[6] = '{32'h13579BDF, 34, 1, 1, 0, 1, 32'h13579BDF, 0, 0};  // two extra edges ignored

    Reset = 1'b1; ClkTx = 1'b0; DataIn = 1'b0; DinValid = 1'b0; ClrErr = 1'b0;
    bus.RxReady = 1'b0;
    repeat (3) tick;
    @(negedge Clk);
    chk("rst_valid", bus.RxValid, 0);
    chk("rst_data",  bus.RxData,  0);
    chk("rst_fe",    FrameErr,    0);
    chk("rst_ov",    Overrun,     0);
    chk("rst_busy",  Busy,        0);
    tick; Reset = 1'b0;
    repeat (2) tick;

    // Normal word with latency checks and hand-decoded fields.
    frame(32'hA53CE127, 32, 1);
    @(negedge Clk);
    chk("norm_opa",   bus.RxOpA,    8'hA5);
    chk("norm_opb",   bus.RxOpB,    8'h3C);
    chk("norm_res",   bus.RxResult, 8'hE1);
    chk("norm_sel",   bus.RxSel,    4'h2);
    chk("norm_flags", bus.RxFlags,  4'h7);
    chk("norm_fe",    FrameErr,     0);

    for (int i = 0; i < 2; i++) runVec(i);

    // Drain the held word, then clear the overrun.
    tick; bus.RxReady = 1'b1; tick; bus.RxReady = 1'b0;
    @(negedge Clk);
    chk("drain_valid", bus.RxValid, 0);
    chk("drain_ov",    Overrun,     1);
    tick; ClrErr = 1'b1; tick; ClrErr = 1'b0;
    @(negedge Clk);
    chk("clr_ov", Overrun, 0);

    for (int i = 2; i < 7; i++) runVec(i);

    // Reset in the middle of a frame.
    tick; DinValid = 1'b1;
    sendBits(32'hCAFEF00D, 10, 0);
    @(negedge Clk);
    chk("mid_busy", Busy, 1);
    tick; Reset = 1'b1; DinValid = 1'b0; ClkTx = 1'b0;
    tick; Reset = 1'b0;
    @(negedge Clk);
    chk("midrst_valid", bus.RxValid,  0);
    chk("midrst_data",  bus.RxData,   0);
    chk("midrst_opa",   bus.RxOpA,    0);
    chk("midrst_flags", bus.RxFlags,  0);
    chk("midrst_fe",    FrameErr,     0);
    chk("midrst_ov",    Overrun,      0);
    chk("midrst_busy",  Busy,         0);
    repeat (3) tick;

    frame(32'hDEADBEEF, 32, 0);
    checkOut("after_rst", 1, 32'hDEADBEEF, 0, 0);
    @(negedge Clk);
    chk("after_rst_sel",   bus.RxSel,   4'hE);
    chk("after_rst_flags", bus.RxFlags, 4'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
